// File: rtl/instr_fetch.sv
// Instruction fetch/issue sequencer: owns the PC, reads instruction memory over req/ack,
// presents the latched instruction and computes the next PC from execute results.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  input  logic        retire,
  output logic        fetch_err
);

  typedef enum logic [2:0] {StReset, StFetch, StIssue, StExec, StError} state_e;

  localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;

  logic [31:0] pc4, br_target, jmp_target;

  assign pc4        = pc_q + 32'd4;
  assign br_target  = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jmp_target = {pc4[31:28], instr_q[25:0], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    wait_d      = wait_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
    unique case (state_q)
      StReset: begin
        wait_d  = 8'd0;
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem_ack) begin
          instr_d = imem_rdata;
          wait_d  = 8'd0;
          state_d = StIssue;
        end else if (wait_q == WaitLast) begin
          state_d = StError;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StIssue: begin
        instr_valid = 1'b1;
        state_d     = StExec;
      end
      StExec: begin
        if (retire) begin
          if (Jump) begin
            pc_d = jmp_target;
          end else if (Branch && Zero) begin
            pc_d = br_target;
          end else begin
            pc_d = pc4;
          end
          wait_d  = 8'd0;
          state_d = StFetch;
        end
      end
      StError: begin
        fetch_err = 1'b1;
      end
      default: begin
        state_d = StReset;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StReset;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against a
// PC model; a second instance with RESET_PC=0xFFFFFFFC shares all inputs.
module tb_instr_fetch;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        Branch = 1'b0, Jump = 1'b0, Zero = 1'b0, retire = 1'b0;

  logic        req_a, valid_a, err_a;
  logic [31:0] addr_a, instr_a, pc_a;
  logic [5:0]  op_a;
  logic        req_b, valid_b, err_b;
  logic [31:0] addr_b, instr_b, pc_b;
  logic [5:0]  op_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 Clk = ~Clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut_a (
    .Clk(Clk), .Rst(Rst), .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr_a), .opcode(op_a), .instr_valid(valid_a),
    .pc(pc_a), .Branch(Branch), .Jump(Jump), .Zero(Zero), .retire(retire),
    .fetch_err(err_a)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(15)) dut_b (
    .Clk(Clk), .Rst(Rst), .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr_b), .opcode(op_b), .instr_valid(valid_b),
    .pc(pc_b), .Branch(Branch), .Jump(Jump), .Zero(Zero), .retire(retire),
    .fetch_err(err_b)
  );

  // Reference next-PC rule, written as plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic b, input logic j, input logic z);
    logic [31:0] p4;
    int          off;
    p4 = cur + 32'd4;
    if (j) return {p4[31:28], ins[25:0], 2'b00};
    if (b && z) begin
      off = int'($signed(ins[15:0])) * 4;
      return p4 + 32'(off);
    end
    return p4;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0; imem_ack = 1'b0; retire = 1'b0;
    Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    step(); step();
    Rst = 1'b1;
    step();
  endtask

  // Full transaction from FETCH: ack with word, pass ISSUE, retire in EXEC.
  task automatic run_instr(input logic [31:0] word, input logic b, input logic j,
                           input logic z);
    imem_ack = 1'b1; imem_rdata = word;
    step();
    imem_ack = 1'b0;
    step();
    Branch = b; Jump = j; Zero = z; retire = 1'b1;
    step();
    retire = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    step();
    tests_run++;
    if (req_a !== 1'b0 || valid_a !== 1'b0 || err_a !== 1'b0 || pc_a !== 32'h0 ||
        instr_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_a: req=%b valid=%b err=%b pc=%h instr=%h, required 0 0 0 0 0",
               req_a, valid_a, err_a, pc_a, instr_a);
    end
    tests_run++;
    if (pc_b !== 32'hFFFF_FFFC || req_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_b: pc=%h req=%b, required fffffffc 0", pc_b, req_b);
    end
    Rst = 1'b1;
    step();
    tests_run++;
    if (req_a !== 1'b1 || addr_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL first_fetch: req=%b addr=%h, required 1 00000000", req_a, addr_a);
    end
  endtask

  task automatic test_sequential();
    imem_ack = 1'b1; imem_rdata = 32'h8C08_0004;
    step();
    imem_ack = 1'b0;
    tests_run++;
    if (valid_a !== 1'b1 || op_a !== 6'b100011 || instr_a !== 32'h8C08_0004 || req_a !== 1'b0)
    begin
      tests_failed++;
      $display("FAIL issue: valid=%b op=%b instr=%h req=%b, required 1 100011 8c080004 0",
               valid_a, op_a, instr_a, req_a);
    end
    // retire during ISSUE must not move pc
    retire = 1'b1; Jump = 1'b1;
    step();
    retire = 1'b0; Jump = 1'b0;
    tests_run++;
    if (valid_a !== 1'b0 || pc_a !== 32'h0 || req_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL issue_retire: valid=%b pc=%h req=%b, required 0 00000000 0",
               valid_a, pc_a, req_a);
    end
    retire = 1'b1;
    step();
    retire = 1'b0;
    tests_run++;
    if (req_a !== 1'b1 || addr_a !== 32'h4) begin
      tests_failed++;
      $display("FAIL seq_next: req=%b addr=%h, required 1 00000004", req_a, addr_a);
    end
  endtask

  task automatic test_branch_jump();
    run_instr(32'h0800_0004, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (addr_a !== 32'h10) begin
      tests_failed++;
      $display("FAIL jump_to_10: addr=%h, required 00000010", addr_a);
    end
    run_instr(32'h1109_FFFF, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (addr_a !== 32'h10) begin
      tests_failed++;
      $display("FAIL beq_taken: addr=%h, required 00000010", addr_a);
    end
    run_instr(32'h1109_FFFF, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (addr_a !== 32'h14) begin
      tests_failed++;
      $display("FAIL beq_not_taken: addr=%h, required 00000014", addr_a);
    end
    run_instr(32'h0800_0008, 1'b0, 1'b1, 1'b0);
    run_instr(32'h0800_0040, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (addr_a !== 32'h100) begin
      tests_failed++;
      $display("FAIL jump_wins: addr=%h, required 00000100", addr_a);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 14; k++) step();
    tests_run++;
    if (err_a !== 1'b0 || req_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_early: err=%b req=%b after 14 waits, required 0 1", err_a, req_a);
    end
    step();
    tests_run++;
    if (err_a !== 1'b1 || req_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout: err=%b req=%b after 15 waits, required 1 0", err_a, req_a);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step(); step();
    imem_ack = 1'b0;
    tests_run++;
    if (err_a !== 1'b1 || req_a !== 1'b0 || valid_a !== 1'b0 || instr_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL late_ack: err=%b req=%b valid=%b instr=%h, required 1 0 0 00000000",
               err_a, req_a, valid_a, instr_a);
    end
    Rst = 1'b0;
    #1;
    tests_run++;
    if (err_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: err=%b, required 0", err_a);
    end
    step();
    Rst = 1'b1;
    step();
    tests_run++;
    if (req_a !== 1'b1 || addr_a !== 32'h0 || err_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL refetch: req=%b addr=%h err=%b, required 1 00000000 0",
               req_a, addr_a, err_a);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tests_run++;
    if (addr_b !== 32'hFFFF_FFFC || req_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_fetch: addr=%h req=%b, required fffffffc 1", addr_b, req_b);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
    step();
    imem_ack = 1'b0;
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    tests_run++;
    if (instr_b !== 32'h0000_0020 || valid_b !== 1'b0 || req_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL exec_ack: instr=%h valid=%b req=%b, required 00000020 0 0",
               instr_b, valid_b, req_b);
    end
    retire = 1'b1;
    step();
    retire = 1'b0;
    tests_run++;
    if (addr_b !== 32'h0 || req_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap: addr=%h req=%b, required 00000000 1", addr_b, req_b);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_instr(32'h0, 1'b0, 1'b0, 1'b0);
    Rst = 1'b0;
    #1;
    tests_run++;
    if (req_a !== 1'b0 || pc_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_in_fetch: req=%b pc=%h, required 0 00000000", req_a, pc_a);
    end
    step();
    Rst = 1'b1;
    step();
    run_instr(32'h0, 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'hA5A5_5A5A;
    step();
    imem_ack = 1'b0;
    step();
    Rst = 1'b0;
    #1;
    tests_run++;
    if (req_a !== 1'b0 || valid_a !== 1'b0 || pc_a !== 32'h0 || instr_a !== 32'h0 ||
        pc_b !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL rst_in_exec: req=%b valid=%b pc=%h instr=%h pc_b=%h, required 0 0 0 0 fffffffc",
               req_a, valid_a, pc_a, instr_a, pc_b);
    end
    step();
    Rst = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [31:0] mpc_a, mpc_b, word;
    logic        b, j, z;
    int unsigned w, gap;
    mpc_a = 32'h0;
    mpc_b = 32'hFFFF_FFFC;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      w = $urandom_range(0, 12);
      for (int k = 0; k < int'(w); k++) step();
      tests_run++;
      if (req_a !== 1'b1 || addr_a !== mpc_a || addr_b !== mpc_b || err_a !== 1'b0) begin
        tests_failed++;
        $display("FAIL rnd_fetch[%0d]: req=%b addr_a=%h addr_b=%h err=%b, required 1 %h %h 0",
                 n, req_a, addr_a, addr_b, err_a, mpc_a, mpc_b);
      end
      word = $urandom;
      if ($urandom_range(0, 3) == 0) word[31:26] = 6'b000010;
      imem_ack = 1'b1; imem_rdata = word;
      step();
      imem_ack = 1'b0;
      tests_run++;
      if (valid_a !== 1'b1 || instr_a !== word || op_a !== word[31:26] || pc_a !== mpc_a) begin
        tests_failed++;
        $display("FAIL rnd_issue[%0d]: valid=%b instr=%h op=%b pc=%h, required 1 %h %b %h",
                 n, valid_a, instr_a, op_a, pc_a, word, word[31:26], mpc_a);
      end
      if ($urandom_range(0, 1) == 1) begin
        retire = 1'b1; Jump = 1'b1;
      end
      step();
      retire = 1'b0; Jump = 1'b0;
      gap = $urandom_range(0, 3);
      for (int k = 0; k < int'(gap); k++) begin
        imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
        step();
      end
      imem_ack = 1'b0;
      tests_run++;
      if (req_a !== 1'b0 || valid_a !== 1'b0 || instr_a !== word || pc_a !== mpc_a) begin
        tests_failed++;
        $display("FAIL rnd_exec[%0d]: req=%b valid=%b instr=%h pc=%h, required 0 0 %h %h",
                 n, req_a, valid_a, instr_a, pc_a, word, mpc_a);
      end
      b = 1'($urandom_range(0, 1));
      j = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      Branch = b; Jump = j; Zero = z; retire = 1'b1;
      step();
      retire = 1'b0; Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
      mpc_a = model_next(mpc_a, word, b, j, z);
      mpc_b = model_next(mpc_b, word, b, j, z);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_jump();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
